// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter between an RX-echo FIFO and a valid/ready requester,
// with round-robin arbitration and a per-launch timeout on the TX_en/TX_status handshake.
module uart_tx_scheduler #(
   parameter int FIFO_DEPTH      = 4,
   parameter int TIMEOUT         = 1023,
   parameter bit ECHO_INVERT_MSB = 1'b1
) (
   input  logic                          sys_clk,
   input  logic                          rst,
   input  logic [7:0]                    RX_data,
   input  logic                          RX_status,
   input  logic [7:0]                    req_data,
   input  logic                          req_valid,
   output logic                          req_ready,
   output logic [7:0]                    TX_data,
   output logic                          TX_en,
   input  logic                          TX_status,
   input  logic                          clr_err,
   output logic                          ovf,
   output logic                          timeout_err,
   output logic                          last_grant,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic [1:0]                    dbg_state_o
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] DEPTH_C = FIFO_DEPTH[AW:0];
   localparam logic [15:0] TMO_C   = TIMEOUT[15:0];

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      BUSY  = 2'd2
   } state_t;

   state_t        state_q;
   logic [7:0]    tx_data_q;
   logic          tx_en_q;
   logic          last_grant_q;
   logic [15:0]   tmo_cnt_q;
   logic [15:0]   tmo_cnt_d;
   logic          tmo_err_q;

   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [AW:0]   count_q;
   logic [AW:0]   count_d;
   logic          ovf_q;

   logic [7:0]    rx_cond;
   logic          fifo_full;
   logic          fifo_empty;
   logic          push_ok;
   logic          ovf_set;
   logic          pop;
   logic          p0;
   logic          p1;
   logic          grant;
   logic          sel_req;

   // Echo bytes with bit7 set are optionally stored inverted before queueing.
   always_comb begin
      rx_cond = RX_data;
      if (ECHO_INVERT_MSB && RX_data[7]) begin
         rx_cond = ~RX_data;
      end
   end

   assign fifo_full  = (count_q == DEPTH_C);
   assign fifo_empty = (count_q == '0);
   assign push_ok    = RX_status && (!fifo_full || pop);
   assign ovf_set    = RX_status && fifo_full && !pop;

   always_comb begin
      count_d = count_q;
      case ({push_ok, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Storage carries no reset: stale entries are unreachable once the pointers clear.
   always_ff @(posedge sys_clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= rx_cond;
      end
   end

   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_d;
         if (ovf_set) begin
            ovf_q <= 1'b1;
         end else if (clr_err) begin
            ovf_q <= 1'b0;
         end
      end
   end

   // Requester handshake: a byte transfers in the cycle req_valid & req_ready are both high;
   // req_ready only rises combinationally in an IDLE cycle that grants the requester.
   assign p0      = !fifo_empty;
   assign p1      = req_valid;
   assign grant   = (state_q == IDLE) && TX_status && (p0 || p1);
   assign sel_req = p1 && (!p0 || !last_grant_q);
   assign pop     = grant && !sel_req;

   assign tmo_cnt_d = tmo_cnt_q + 16'd1;

   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         tx_data_q    <= 8'h00;
         tx_en_q      <= 1'b0;
         last_grant_q <= 1'b1;
         tmo_cnt_q    <= 16'd0;
         tmo_err_q    <= 1'b0;
      end else begin
         // A timeout in the same cycle overrides this clear below.
         if (clr_err) tmo_err_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (grant) begin
                  tx_data_q    <= sel_req ? req_data : mem_q[rd_ptr_q];
                  tx_en_q      <= 1'b1;
                  last_grant_q <= sel_req;
                  tmo_cnt_q    <= 16'd0;
                  state_q      <= START;
               end
            end
            START: begin
               tmo_cnt_q <= tmo_cnt_d;
               if (!TX_status) begin
                  tx_en_q <= 1'b0;
                  state_q <= BUSY;
               end else if (tmo_cnt_d == TMO_C) begin
                  tx_en_q   <= 1'b0;
                  tmo_err_q <= 1'b1;
                  state_q   <= IDLE;
               end
            end
            BUSY: begin
               if (TX_status) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign req_ready   = grant && sel_req;
   assign TX_data     = tx_data_q;
   assign TX_en       = tx_en_q;
   assign ovf         = ovf_q;
   assign timeout_err = tmo_err_q;
   assign last_grant  = last_grant_q;
   assign fifo_count  = count_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: echo path, requester, contention, overflow,
// full push+pop, launch timeout and reset mid-transfer.
module tb_uart_tx_scheduler;

   localparam int DEPTH = 4;
   localparam int TMO   = 8;

   logic       sys_clk = 1'b0;
   logic       rst;
   logic [7:0] RX_data;
   logic       RX_status;
   logic [7:0] req_data;
   logic       req_valid;
   logic       req_ready;
   logic [7:0] TX_data;
   logic       TX_en;
   logic       TX_status;
   logic       clr_err;
   logic       ovf;
   logic       timeout_err;
   logic       last_grant;
   logic [2:0] fifo_count;
   logic [1:0] dbg_state;

   int compared   = 0;
   int mismatched = 0;
   int rdy_pulses = 0;
   int rdy_base;
   int hi;
   logic any_en;
   logic [7:0] exp_q[$];

   uart_tx_scheduler #(
      .FIFO_DEPTH      (DEPTH),
      .TIMEOUT         (TMO),
      .ECHO_INVERT_MSB (1'b1)
   ) dut (
      .sys_clk     (sys_clk),
      .rst         (rst),
      .RX_data     (RX_data),
      .RX_status   (RX_status),
      .req_data    (req_data),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .TX_data     (TX_data),
      .TX_en       (TX_en),
      .TX_status   (TX_status),
      .clr_err     (clr_err),
      .ovf         (ovf),
      .timeout_err (timeout_err),
      .last_grant  (last_grant),
      .fifo_count  (fifo_count),
      .dbg_state_o (dbg_state)
   );

   always #5 sys_clk = ~sys_clk;

   always @(posedge sys_clk) begin
      if (req_valid && req_ready) rdy_pulses <= rdy_pulses + 1;
   end

   task automatic step();
      @(negedge sys_clk);
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Waits for a launch, checks the byte against the expected queue, then plays
   // a transmitter that stays busy for busy_len cycles.
   task automatic serve(input int busy_len, input string tag);
      int n;
      logic [7:0] exp;
      n = 0;
      while (TX_en !== 1'b1 && n < 40) begin
         step();
         n++;
      end
      chk({tag, "_launch"}, 16'(n < 40), 16'd1);
      exp = 8'h00;
      if (exp_q.size() > 0) exp = exp_q.pop_front();
      chk({tag, "_data"}, 16'(TX_data), 16'(exp));
      TX_status = 1'b0;
      repeat (busy_len) step();
      TX_status = 1'b1;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; RX_data = 8'h00; RX_status = 1'b0; req_data = 8'h00;
      req_valid = 1'b0; TX_status = 1'b1; clr_err = 1'b0;
      repeat (2) step();
      chk("rst_tx_data", 16'(TX_data), 16'h00);
      chk("rst_tx_en", 16'(TX_en), 16'd0);
      chk("rst_req_ready", 16'(req_ready), 16'd0);
      chk("rst_ovf", 16'(ovf), 16'd0);
      chk("rst_tmo_err", 16'(timeout_err), 16'd0);
      chk("rst_last_grant", 16'(last_grant), 16'd1);
      chk("rst_fifo_count", 16'(fifo_count), 16'd0);
      chk("rst_state", 16'(dbg_state), 16'd0);
      rst = 1'b0;
      step();

      // Echo path: 0x41 passes through, 0xC3 is stored inverted as 0x3C
      RX_data = 8'h41; RX_status = 1'b1; exp_q.push_back(8'h41);
      step(); RX_status = 1'b0;
      chk("echo1_cnt_c1", 16'(fifo_count), 16'd1);
      chk("echo1_en_c1", 16'(TX_en), 16'd0);
      step();
      chk("echo1_en_c2", 16'(TX_en), 16'd1);
      serve(10, "echo1");
      step(); step();
      chk("echo1_idle", 16'(TX_en), 16'd0);
      RX_data = 8'hC3; RX_status = 1'b1; exp_q.push_back(8'h3C);
      step(); RX_status = 1'b0;
      chk("echo2_en_c1", 16'(TX_en), 16'd0);
      step();
      chk("echo2_en_c2", 16'(TX_en), 16'd1);
      serve(10, "echo2");
      chk("echo_ovf", 16'(ovf), 16'd0);
      chk("echo_last_grant", 16'(last_grant), 16'd0);
      step(); step();

      // Requester alone: ready in the grant cycle, TX_en the cycle after
      req_data = 8'h5A; req_valid = 1'b1; exp_q.push_back(8'h5A);
      #1;
      chk("req_ready_grant", 16'(req_ready), 16'd1);
      step();
      chk("req_ready_after", 16'(req_ready), 16'd0);
      req_valid = 1'b0;
      chk("req_en_next", 16'(TX_en), 16'd1);
      chk("req_last_grant", 16'(last_grant), 16'd1);
      serve(2, "req");
      step(); step();

      // Contention: two echo bytes and two requester bytes pending together
      TX_status = 1'b0;
      RX_data = 8'h10; RX_status = 1'b1; step();
      RX_data = 8'h11; step();
      RX_status = 1'b0;
      chk("cont_fifo_count", 16'(fifo_count), 16'd2);
      rdy_base = rdy_pulses;
      exp_q.push_back(8'h10); exp_q.push_back(8'h20);
      exp_q.push_back(8'h11); exp_q.push_back(8'h21);
      req_data = 8'h20; req_valid = 1'b1; TX_status = 1'b1;
      #1;
      chk("cont_first_not_req", 16'(req_ready), 16'd0);
      serve(2, "cont0");
      serve(2, "cont1");
      req_data = 8'h21;
      serve(2, "cont2");
      serve(2, "cont3");
      req_valid = 1'b0;
      repeat (3) step();
      chk("cont_ready_pulses", 16'(rdy_pulses - rdy_base), 16'd2);

      // Overflow: five strobes into a depth-4 FIFO while the transmitter is busy
      TX_status = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         RX_data = 8'(i); RX_status = 1'b1;
         step();
      end
      RX_status = 1'b0;
      chk("ovf_fifo_count", 16'(fifo_count), 16'd4);
      chk("ovf_flag", 16'(ovf), 16'd1);
      clr_err = 1'b1; step(); clr_err = 1'b0;
      chk("ovf_cleared", 16'(ovf), 16'd0);
      for (int i = 1; i <= 4; i++) exp_q.push_back(8'(i));
      TX_status = 1'b1;
      for (int i = 0; i < 4; i++) serve(2, "ovf_drain");
      repeat (6) step();
      chk("ovf_no_fifth", 16'(TX_en), 16'd0);
      chk("ovf_empty", 16'(fifo_count), 16'd0);

      // Full FIFO with an echo grant and an RX strobe in the same cycle
      TX_status = 1'b0;
      for (int i = 0; i < 4; i++) begin
         RX_data = 8'h31 + 8'(i); RX_status = 1'b1;
         step();
      end
      RX_status = 1'b0;
      chk("full_pre_count", 16'(fifo_count), 16'd4);
      step();
      TX_status = 1'b1; RX_data = 8'h35; RX_status = 1'b1;
      step(); RX_status = 1'b0;
      chk("full_pp_count", 16'(fifo_count), 16'd4);
      chk("full_pp_ovf", 16'(ovf), 16'd0);
      chk("full_pp_en", 16'(TX_en), 16'd1);
      for (int i = 0; i < 5; i++) exp_q.push_back(8'h31 + 8'(i));
      for (int i = 0; i < 5; i++) serve(2, "full_pp");
      step(); step();
      chk("full_pp_empty", 16'(fifo_count), 16'd0);

      // Timeout: transmitter never goes busy for the first launch
      TX_status = 1'b0;
      RX_data = 8'h66; RX_status = 1'b1; step();
      RX_data = 8'h77; step();
      RX_status = 1'b0; TX_status = 1'b1;
      step();
      chk("tmo_data", 16'(TX_data), 16'h66);
      hi = 0;
      while (TX_en === 1'b1 && hi < 20) begin
         hi++;
         step();
      end
      chk("tmo_en_len", 16'(hi), 16'(TMO));
      chk("tmo_err_set", 16'(timeout_err), 16'd1);
      exp_q.push_back(8'h77);
      serve(2, "tmo_next");
      clr_err = 1'b1; step(); clr_err = 1'b0;
      chk("tmo_err_cleared", 16'(timeout_err), 16'd0);
      step(); step();

      // Reset while BUSY with two bytes queued
      RX_data = 8'h12; RX_status = 1'b1; step();
      RX_data = 8'h13; step();
      RX_data = 8'h14; TX_status = 1'b0; step();
      RX_status = 1'b0;
      chk("rstm_pre_state", 16'(dbg_state), 16'd2);
      chk("rstm_pre_count", 16'(fifo_count), 16'd2);
      #1 rst = 1'b1;
      #1;
      chk("rstm_tx_en", 16'(TX_en), 16'd0);
      chk("rstm_count", 16'(fifo_count), 16'd0);
      chk("rstm_tx_data", 16'(TX_data), 16'h00);
      chk("rstm_last_grant", 16'(last_grant), 16'd1);
      chk("rstm_state", 16'(dbg_state), 16'd0);
      step(); step();
      TX_status = 1'b1; rst = 1'b0;
      any_en = 1'b0;
      repeat (6) begin
         step();
         if (TX_en !== 1'b0) any_en = 1'b1;
      end
      chk("rstm_quiet", 16'(any_en), 16'd0);
      req_data = 8'h99; req_valid = 1'b1; exp_q.push_back(8'h99);
      #1;
      chk("rstm_new_ready", 16'(req_ready), 16'd1);
      step(); req_valid = 1'b0;
      serve(2, "rstm_new");
      repeat (3) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Shares the single UART transmitter between two byte sources: the receive-echo path (bytes arriving on the RX strobe, buffered in a small FIFO and optionally MSB-conditioned) and a host/requester channel using a valid/ready handshake. It arbitrates round-robin and drives the transmitter's `TX_data`/`TX_en` strobe using the `TX_status` handshake. It supervises each launch with a timeout. It sits between the UART receiver, the transmitter and any on-chip message source.

## Interface
Parameters:
- `FIFO_DEPTH`, 4: echo FIFO entries; power of two, 2..16.
- `TIMEOUT`, 1023: max cycles `TX_en` may stay high without the transmitter going busy; 1..65535.
- `ECHO_INVERT_MSB`, 1: when 1, an echo byte with bit7=1 is stored bitwise-inverted; when 0, it is stored unchanged.

Ports:
- `sys_clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `RX_data`  in  8  received byte.
- `RX_status`  in  1  one-cycle strobe: `RX_data` valid; push into echo FIFO.
- `req_data`  in  8  requester byte.
- `req_valid`  in  1  requester has a byte; must hold `req_data` stable until accepted.
- `req_ready`  out  1  accept strobe; transfer when `req_valid & req_ready`.
- `TX_data`  out  8  byte to transmitter.
- `TX_en`  out  1  launch request to transmitter.
- `TX_status`  in  1  1 = transmitter idle, 0 = busy sending.
- `clr_err`  in  1  synchronous clear of `ovf` and `timeout_err`.
- `ovf`  out  1  sticky: echo byte dropped, FIFO full.
- `timeout_err`  out  1  sticky: launch timed out, byte dropped.
- `last_grant`  out  1  channel last served (0 = echo, 1 = requester).
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  echo FIFO occupancy.

## Operation
- Reset values: `TX_data`=0, `TX_en`=0, `req_ready`=0, `ovf`=0, `timeout_err`=0, `last_grant`=1 (echo wins first contention), `fifo_count`=0, FSM=IDLE, timeout counter=0. Asserting `rst` mid-transfer aborts immediately. FIFO contents are discarded.
- Echo FIFO push occurs on `RX_status`, with the MSB transform applied before storage.
- If the FIFO is full with no pop in the same cycle, the byte is dropped and `ovf` is set.
- If the FIFO is full and a pop occurs in the same cycle, the push succeeds and `fifo_count` is unchanged.
- Pending flags: `p0` = FIFO non-empty; `p1` = `req_valid`.
- FSM states: IDLE, START, BUSY.
  - IDLE, when `TX_status`=1 and `p0|p1`: select a channel. If only one is pending, select it. If both are pending, select the channel ≠ `last_grant`. The selected byte is registered into `TX_data`, `TX_en`<=1, `last_grant` updates, the timeout counter clears, and the FSM goes to START. An echo grant pops the FIFO. A requester grant drives `req_ready`=1 combinationally for that cycle only.
  - IDLE with `TX_status`=0: no grant; `req_ready`=0.
  - START: `TX_en` held high and the counter increments.
    - If `TX_status`=0: `TX_en`<=0 and go to BUSY.
    - Else if the counter reaches `TIMEOUT`: `TX_en`<=0, `timeout_err`<=1, go to IDLE. The byte is lost and not retried.
  - BUSY: wait for `TX_status`=1, then go to IDLE.
- `req_ready` is 0 in every state except the IDLE requester-grant cycle.
- `clr_err` clears both sticky flags. If `clr_err` and a set event occur in the same cycle, the set wins.
- `TX_data` holds its value until the next grant.

## Timing
- Echo latency: `RX_status` in cycle 0 with FIFO empty, FSM IDLE and `TX_status`=1 gives the grant in cycle 1 and `TX_en`=1 from cycle 2.
- Requester: `req_ready` is high in the same cycle as the grant; `TX_en`=1 in the following cycle.
- `TX_en` falls one cycle after the first cycle in which `TX_status`=0 is sampled during START.
- The earliest next grant is the cycle after `TX_status` returns to 1 in BUSY. Minimum spacing is 3 cycles per byte with an instant transmitter.
- A timeout fires after `TIMEOUT` START cycles. `TX_en` is low in the next cycle.

## Test plan
- Echo path with `ECHO_INVERT_MSB`=1: RX bytes 0x41 then 0xC3, transmitter model busy for 10 cycles → `TX_data` sequence 0x41, 0x3C; `TX_en` high 2 cycles after each strobe when idle; `ovf`=0.
- Contention: FIFO holding 0x10,0x11 and `req_valid` with 0x20,0x21 all pending at once → launch order 0x10, 0x20, 0x11, 0x21; `req_ready` pulses exactly twice.
- Overflow: 5 RX strobes on consecutive cycles while `TX_status`=0 (depth 4) → `fifo_count`=4, `ovf`=1. The 5th byte is absent from TX output. `clr_err` then clears `ovf`.
- Full push+pop: FIFO full and FSM granting echo in the same cycle as an `RX_status` → `fifo_count` stays 4, no `ovf`, and the new byte is transmitted last.
- Timeout with `TIMEOUT`=8: `TX_status` stuck at 1 after a grant → `TX_en` high for 8 cycles then low, `timeout_err`=1. The next pending byte is still granted afterward.
- Reset mid-transfer: assert `rst` in BUSY with 2 bytes queued → `TX_en`=0, `fifo_count`=0 and all outputs at reset values immediately. No TX activity follows release until new input arrives.
